// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch controller and its instruction buffer.
package fetch_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } buf_entry_t;

endpackage

// File: rtl/fetch_buf_fifo.sv
// Small circular FIFO holding fetched {pc, instr} entries; flush empties it in one edge.
module fetch_buf_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  buf_entry_t                 pushData_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output buf_entry_t                 headData_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  buf_entry_t     mem_q [DEPTH];
  logic [AW-1:0]  wrPtr_q, rdPtr_q;
  logic [CW-1:0]  count_q;
  logic           doPush, doPop;

  // A pop on an empty buffer is ignored; a push is only refused when full and not popping.
  assign doPop  = pop_i && (count_q != '0);
  assign doPush = push_i && ((count_q != CW'(DEPTH)) || doPop);

  always_ff @(posedge clk) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= pushData_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + CW'(doPush) - CW'(doPop);
    end
  end

  assign headData_o = mem_q[rdPtr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage sequencer: owns the PC, issues fetches, buffers responses and hands them to decode.
module fetch_control
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 16'h0000,
  parameter int              BUF_DEPTH = 2,
  parameter logic [PC_W-1:0] PC_STEP   = 16'd2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt,
  output logic               fetch_en,
  output logic [PC_W-1:0]    fetch_addr,
  input  logic               fetch_ready,
  input  logic [INSTR_W-1:0] fetch_instr,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ack,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_addr,
  output logic               busy
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, inflightPc_q;
  logic            inflight_q;
  buf_entry_t      head, lastHead_q, pushEntry;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            push, pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A redirect cycle freezes the state machine so start/halt cannot act on the same edge.
  always_comb begin
    state_d = state_q;
    if (!redirect_valid) begin
      unique case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (halt)  state_d = HALTED;
        HALTED:  if (!halt) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Occupancy counts the outstanding fetch so a full buffer can never be overrun.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};

  always_comb begin
    fetch_en = (state_q == RUN) && !redirect_valid && (occupancy < (CW+1)'(BUF_DEPTH));
    busy     = (state_q != IDLE);
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_addr & 16'hFFFE;
    else if (fetch_en)  pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
      lastHead_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= fetch_en;
      if (fetch_en)    inflightPc_q <= pc_q;
      if (instr_valid) lastHead_q   <= head;
    end
  end

  assign push      = fetch_ready && inflight_q && !redirect_valid;
  assign pop       = instr_ack && instr_valid && !redirect_valid;
  assign pushEntry = '{pc: inflightPc_q, instr: fetch_instr};

  fetch_buf_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .pushData_i(pushEntry),
    .pop_i     (pop),
    .flush_i   (redirect_valid),
    .headData_o(head),
    .count_o   (count)
  );

  assign fetch_addr  = pc_q;
  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? head.instr : lastHead_q.instr;
  assign instr_pc    = instr_valid ? head.pc    : lastHead_q.pc;

endmodule

// File: tb/tb_fetch_control.sv
// Directed and randomized bench for fetch_control against a queue-based reference model.
module tb_fetch_control;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, halt = 1'b0, instr_ack = 1'b0, redirect_valid = 1'b0;
  logic [15:0] redirect_addr = '0;
  logic        fetch_ready = 1'b0;
  logic [15:0] fetch_instr = '0;
  logic        fetch_en, instr_valid, busy;
  logic [15:0] fetch_addr, instr_data, instr_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        q[$];
  int          mState;
  logic [15:0] mPc, mIpc, lastPc, lastData, respAddr;
  bit          mInflight, respPending, haltLvl;

  always #5 clk = ~clk;

  fetch_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .halt          (halt),
    .fetch_en      (fetch_en),
    .fetch_addr    (fetch_addr),
    .fetch_ready   (fetch_ready),
    .fetch_instr   (fetch_instr),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ack     (instr_ack),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .busy          (busy)
  );

  function automatic logic [15:0] instrOf(input logic [15:0] addr);
    case (addr)
      16'h0000: return 16'h0102;
      16'h0002: return 16'h0326;
      16'h0010: return 16'h7040;
      default:  return (addr * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mState = 0; mPc = 16'h0000; mIpc = 16'h0000; mInflight = 0;
    q.delete(); lastPc = 16'h0000; lastData = 16'h0000; respPending = 0;
  endtask

  // Reset is asserted at a negedge and its effect checked before any clock edge.
  task automatic doReset();
    start = 0; halt = 0; instr_ack = 0; redirect_valid = 0; fetch_ready = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_fetch_en", fetch_en, 1'b0);
    checkOutput("rst_fetch_addr", fetch_addr, 16'h0000);
    checkOutput("rst_instr_valid", instr_valid, 1'b0);
    checkOutput("rst_instr_data", instr_data, 16'h0000);
    checkOutput("rst_instr_pc", instr_pc, 16'h0000);
    checkOutput("rst_busy", busy, 1'b0);
    modelReset();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
  task automatic applyStimulus(input bit st, input bit hl, input bit ak,
                               input bit rv, input logic [15:0] ra);
    bit expEn;
    start = st; halt = hl; instr_ack = ak; redirect_valid = rv; redirect_addr = ra;
    if (respPending) begin
      fetch_ready = 1; fetch_instr = instrOf(respAddr);
    end else begin
      fetch_ready = ($urandom_range(5) == 0);
      fetch_instr = 16'($urandom);
    end
    #1;
    expEn = (mState == 1) && !rv && ((q.size() + int'(mInflight)) < DEPTH);
    checkOutput("fetch_en", fetch_en, expEn);
    checkOutput("fetch_addr", fetch_addr, mPc);
    checkOutput("busy", busy, mState != 0);
    checkOutput("instr_valid", instr_valid, q.size() > 0);
    checkOutput("instr_pc", instr_pc, (q.size() > 0) ? q[0].pc : lastPc);
    checkOutput("instr_data", instr_data, (q.size() > 0) ? q[0].instr : lastData);
    respPending = fetch_en;
    respAddr    = fetch_addr;
    if (q.size() > 0) begin
      lastPc = q[0].pc; lastData = q[0].instr;
    end
    if (rv) begin
      mPc = ra & 16'hFFFE; q.delete(); mInflight = 0;
    end else begin
      if (ak && q.size() > 0) void'(q.pop_front());
      if (fetch_ready && mInflight) q.push_back('{mIpc, fetch_instr});
      mIpc = mPc;
      if (expEn) mPc = mPc + 16'd2;
      mInflight = expEn;
      case (mState)
        0: if (st)  mState = 1;
        1: if (hl)  mState = 2;
        2: if (!hl) mState = 1;
        default: mState = 0;
      endcase
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    doReset();

    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("first_valid", instr_valid, 1'b1);
    checkOutput("first_pc", instr_pc, 16'h0000);
    checkOutput("first_data", instr_data, 16'h0102);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("second_pc", instr_pc, 16'h0002);
    checkOutput("second_data", instr_data, 16'h0326);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 0);

    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 0);

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 16'h0011);
    checkOutput("redir_empty", instr_valid, 1'b0);
    checkOutput("redir_addr", fetch_addr, 16'h0010);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("redir_pc", instr_pc, 16'h0010);
    checkOutput("redir_data", instr_data, 16'h7040);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 0);

    applyStimulus(0, 0, 1, 1, 16'hFFFE);
    checkOutput("wrap_addr", fetch_addr, 16'hFFFE);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("wrap_next", fetch_addr, 16'h0000);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("wrap_pc0", instr_pc, 16'hFFFE);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("wrap_pc1", instr_pc, 16'h0000);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);

    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);

    haltLvl = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9) == 0) haltLvl = !haltLvl;
      applyStimulus($urandom_range(19) == 0, haltLvl, $urandom_range(9) < 6,
                    $urandom_range(15) == 0, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
